pixel_point_processor: RTL
==========================

# pixel_point_processor

Parametrised, pipelined per-pixel point processor that supersedes the single-function brightness stage of the image pipeline. It accepts packed colour samples over a valid/ready stream, applies one of four per-frame operations (bypass, threshold, signed saturating brightness, invert) to every lane, and emits the result with matching framing. It sits between the input unpacker and the output packer; `done` marks frame completion for the top-level controller.

## Interface
- DATA_WIDTH, 32, stream width in bits; must be a multiple of COLOR_SIZE (32 or 64 supported).
- COLOR_SIZE, 8, bits per colour sample; LANES = DATA_WIDTH/COLOR_SIZE.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- mode  in  2  0 bypass, 1 threshold, 2 brightness, 3 invert; sampled at frame start.
- proc_val  in  COLOR_SIZE  threshold level (unsigned) or brightness offset (two's complement); sampled at frame start.
- in_vld  in  1  input beat valid.
- in_rdy  out  1  block can accept a beat this cycle.
- in_last  in  1  beat is the last of the frame.
- data_in  in  DATA_WIDTH  packed samples, lane i = data_in[i*COLOR_SIZE +: COLOR_SIZE].
- data_out  out  DATA_WIDTH  processed samples, same lane order.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  downstream accepts the beat.
- out_last  out  1  output beat is the last of the frame.
- done  out  1  one-cycle pulse when the out_last beat is accepted.
- frame_beats  out  16  beat count of the most recently completed frame (saturates at 0xFFFF).

## Operation
- Frame FSM: IDLE, RUN. IDLE + accepted beat (in_vld & in_rdy): latch mode/proc_val into cfg registers; if in_last stay IDLE, else go RUN. RUN + accepted beat with in_last: go IDLE. mode/proc_val changes while RUN are ignored.
- Config travels with each beat through the pipeline, so back-to-back frames with different modes are processed correctly with no bubble.
- Stage 1 (S1): registers data, last, cfg. Stage 2 (S2): computes and registers data_out/out_last/out_vld.
- Per lane, p = sample, v = cfg proc_val, MAX = 2^COLOR_SIZE-1:
  - mode 0: p.
  - mode 1: p >= v (unsigned) ? MAX : 0.
  - mode 2: s = zero-extended p + sign-extended v in COLOR_SIZE+2 bits; s<0 -> 0; s>MAX -> MAX; else s.
  - mode 3: MAX - p.
- Lanes are independent; no carry between lanes.
- Beat counter increments on each accepted output beat; on accepted out_last beat, frame_beats <= count+1 (saturating), counter clears, done pulses next cycle... no: done is registered high in the cycle after acceptance, for exactly one cycle.

## Timing
- Reset values: in_rdy 0 during reset then 1 first cycle after, out_vld 0, out_last 0, data_out 0, done 0, frame_beats 0; FSM IDLE; S1/S2 valid cleared; cfg 0.
- Reset mid-frame: all in-flight beats discarded, no done pulse; next accepted beat starts a new frame.
- Latency: beat accepted in cycle N appears on out_vld in cycle N+2 with out_rdy high.
- Throughput: one beat per cycle when out_rdy held high.
- Advance rules: S2 loads when !out_vld or out_rdy; S1 loads when !S1_vld or S2 loads; in_rdy = !S1_vld or S2 loads (combinational from out_rdy, no skid buffer).
- out_vld, data_out, out_last stable while out_vld & !out_rdy.
- Maximum in-flight beats: 2; with out_rdy low, in_rdy drops after two accepted beats.
- Single-beat frame (first beat has in_last): valid; done pulses once; frame_beats = 1.
- done of frame k and first output of frame k+1 may coincide.

## Test plan
- Brightness, proc_val 0x20, beat 0x007FE0FF, last -> data_out 0x209FFFFF at N+2, out_last 1, done 1 at N+3, frame_beats 1.
- Brightness, proc_val 0xD0 (-48), beat 0x103080FF -> 0x000050CF (negative clamps to 0).
- Threshold 0x80, beats 0x7F8000FF, 0x01020304(last) -> 0x00FF00FF, 0x00000000; mode driven to 2 after first beat -> second beat still thresholded.
- Backpressure: 4-beat bypass frame 0x1..0x4, out_rdy low cycles 2-5 -> in_rdy low after 2 accepts, outputs 0x1..0x4 in order, each held stable, single done, frame_beats 4.
- Back-to-back frames: invert 1 beat 0x00FF1080 then brightness +1 1 beat 0xFEFF0000, no idle -> 0xFF00EF7F, 0xFFFF0101, two done pulses.
- rst_n low one cycle with 2 beats in flight -> out_vld 0 next cycle, no done, frame_beats unchanged at 0; DATA_WIDTH=64 invert 0x0001020304050607 -> 0xFFFEFDFCFBFAF9F8.

Source files
------------

// File: rtl/pixel_point_processor_if.sv
// Stream bundle for the pixel point processor.
//
// Handshake: a beat transfers on a rising clock edge when both the valid
// (in_vld / out_vld) and ready (in_rdy / out_rdy) of that direction are high.
// A producer holding valid high keeps its data/last stable until the transfer
// happens; ready may change freely and may depend combinationally on the
// other side's ready.
//
// Signals:
//   in_vld, in_last, data_in : upstream beat into the processor
//   in_rdy                   : processor can take a beat this cycle
//   data_out, out_vld, out_last : processed beat towards the packer
//   out_rdy                  : packer accepts the beat
//
// Modports:
//   slave  : processor view
//   master : environment view (unpacker side plus packer side)
interface pixel_point_processor_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_vld;
    logic                  in_rdy;
    logic                  in_last;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_vld;
    logic                  out_rdy;
    logic                  out_last;

    modport slave (
        input  in_vld, in_last, data_in, out_rdy,
        output in_rdy, data_out, out_vld, out_last
    );

    modport master (
        output in_vld, in_last, data_in, out_rdy,
        input  in_rdy, data_out, out_vld, out_last
    );
endinterface

// File: rtl/pixel_point_processor.sv
// Pipelined per-pixel point processor.
//
// Every lane of a packed beat gets the same per-frame operation:
//   mode 0 bypass, 1 threshold, 2 signed saturating brightness, 3 invert.
// mode/proc_val are captured on the first beat of a frame and travel with
// each beat, so consecutive frames may use different operations with no gap.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   mode         : operation select, sampled at frame start
//   proc_val     : threshold level or brightness offset, sampled at frame start
//   bus          : stream bundle (slave modport), see pixel_point_processor_if
//   done         : one-cycle pulse the cycle after the last output beat is taken
//   frame_beats  : beat count of the last completed frame (saturating)
//   state_dbg    : frame FSM state (0 IDLE, 1 RUN)
module pixel_point_processor #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [COLOR_SIZE-1:0] proc_val,
    pixel_point_processor_if.slave bus,
    output logic                  done,
    output logic [15:0]           frame_beats,
    output logic                  state_dbg
);
    localparam int LANES = DATA_WIDTH / COLOR_SIZE;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                  state, state_next;
    logic [1:0]              cfg_mode;
    logic [COLOR_SIZE-1:0]   cfg_val;
    logic [1:0]              beat_mode;
    logic [COLOR_SIZE-1:0]   beat_val;

    logic                    s1_vld, s1_last;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [1:0]              s1_mode;
    logic [COLOR_SIZE-1:0]   s1_val;

    logic                    s2_vld, s2_last;
    logic [DATA_WIDTH-1:0]   s2_data;

    logic                    s1_load, s2_load, in_acc, out_acc;
    logic [DATA_WIDTH-1:0]   proc_data;
    logic [COLOR_SIZE-1:0]   lane_p;
    logic [COLOR_SIZE+1:0]   lane_sum;
    logic [15:0]             beat_cnt;

    // No skid buffer: in_rdy follows out_rdy combinationally through s2_load.
    assign s2_load      = !s2_vld || bus.out_rdy;
    assign s1_load      = !s1_vld || s2_load;
    assign bus.in_rdy   = rst_n && s1_load;
    assign in_acc       = bus.in_vld && bus.in_rdy;
    assign out_acc      = s2_vld && bus.out_rdy;

    assign bus.out_vld  = s2_vld;
    assign bus.out_last = s2_last;
    assign bus.data_out = s2_data;
    assign state_dbg    = (state == RUN);

    // Frame FSM; the first beat of a frame uses the live mode/proc_val,
    // later beats use the copy latched at frame start.
    always_comb begin
        state_next = state;
        beat_mode  = cfg_mode;
        beat_val   = cfg_val;
        case (state)
            IDLE: begin
                beat_mode = mode;
                beat_val  = proc_val;
                if (in_acc && !bus.in_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (in_acc && bus.in_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lane arithmetic on the S1 beat. Brightness works in COLOR_SIZE+2 bits:
    // the top bit flags a negative sum, the next one an overflow past MAX.
    always_comb begin
        proc_data = '0;
        lane_p    = '0;
        lane_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_p   = s1_data[i*COLOR_SIZE +: COLOR_SIZE];
            lane_sum = {2'b00, lane_p} + {{2{s1_val[COLOR_SIZE-1]}}, s1_val};
            case (s1_mode)
                2'd0: proc_data[i*COLOR_SIZE +: COLOR_SIZE] = lane_p;
                2'd1: proc_data[i*COLOR_SIZE +: COLOR_SIZE] =
                          (lane_p >= s1_val) ? {COLOR_SIZE{1'b1}} : {COLOR_SIZE{1'b0}};
                2'd2: begin
                    if (lane_sum[COLOR_SIZE+1]) begin
                        proc_data[i*COLOR_SIZE +: COLOR_SIZE] = {COLOR_SIZE{1'b0}};
                    end else if (lane_sum[COLOR_SIZE]) begin
                        proc_data[i*COLOR_SIZE +: COLOR_SIZE] = {COLOR_SIZE{1'b1}};
                    end else begin
                        proc_data[i*COLOR_SIZE +: COLOR_SIZE] = lane_sum[COLOR_SIZE-1:0];
                    end
                end
                default: proc_data[i*COLOR_SIZE +: COLOR_SIZE] = ~lane_p;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg_mode    <= '0;
            cfg_val     <= '0;
            s1_vld      <= 1'b0;
            s1_last     <= 1'b0;
            s1_data     <= '0;
            s1_mode     <= '0;
            s1_val      <= '0;
            s2_vld      <= 1'b0;
            s2_last     <= 1'b0;
            s2_data     <= '0;
            beat_cnt    <= '0;
            frame_beats <= '0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            if (in_acc && state == IDLE) begin
                cfg_mode <= mode;
                cfg_val  <= proc_val;
            end

            if (s1_load) begin
                s1_vld  <= in_acc;
                s1_last <= bus.in_last;
                s1_data <= bus.data_in;
                s1_mode <= beat_mode;
                s1_val  <= beat_val;
            end

            if (s2_load) begin
                s2_vld  <= s1_vld;
                s2_last <= s1_vld && s1_last;
                if (s1_vld) begin
                    s2_data <= proc_data;
                end
            end

            done <= out_acc && s2_last;
            if (out_acc) begin
                if (s2_last) begin
                    frame_beats <= (beat_cnt == 16'hFFFF) ? 16'hFFFF : beat_cnt + 16'd1;
                    beat_cnt    <= '0;
                end else if (beat_cnt != 16'hFFFF) begin
                    beat_cnt <= beat_cnt + 16'd1;
                end
            end
        end
    end
endmodule
